// File: rtl/tiro_nave.sv
// Ship-projectile controller: launches a single shot from the player ship on a
// fire-button edge, raises it by VEL pixels every motion tick, and retires it
// at the top edge or when an enemy reports a hit. A cooldown of RECARGA_TICKS
// ticks separates a retired shot from the next launch.
//
// Ports:
//   CLOCK_50      in   1   system clock
//   reset         in   1   synchronous active-high full clear
//   reiniciarJogo in   1   synchronous game restart (same effect as reset)
//   pausa         in   1   freezes tick counter, motion, cooldown and launches
//   disparo       in   1   fire button level (synchronised)
//   nave_x/nave_y in   10  ship position, sampled at launch
//   acerto        in   1   OR of enemy hit flags
//   bola_nave_x/y out  10  shot position, parked at (0,0) when idle
//   ativa         out  1   shot in flight
//   disparos      out  8   launches since reset, saturating at 255
module tiro_nave #(
  parameter int unsigned TICK_DIV      = 320000,
  parameter int unsigned VEL           = 4,
  parameter int unsigned OFFSET_X      = 16,
  parameter int unsigned Y_TOPO        = 8,
  parameter int unsigned RECARGA_TICKS = 10
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       reiniciarJogo,
  input  logic       pausa,
  input  logic       disparo,
  input  logic [9:0] nave_x,
  input  logic [9:0] nave_y,
  input  logic       acerto,
  output logic [9:0] bola_nave_x,
  output logic [9:0] bola_nave_y,
  output logic       ativa,
  output logic [7:0] disparos
);

  localparam int unsigned POS_W = 10;
  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CD_W  = (RECARGA_TICKS > 2) ? $clog2(RECARGA_TICKS) : 1;
  localparam int unsigned DSP_W = 8;

  typedef enum logic [1:0] {
    OCIOSA  = 2'd0,
    VOANDO  = 2'd1,
    RECARGA = 2'd2
  } estado_t;

  estado_t          state_q, state_d;
  logic [POS_W-1:0] x_q, x_d;
  logic [POS_W-1:0] y_q, y_d;
  logic             ativa_q, ativa_d;
  logic [DSP_W-1:0] disparos_q, disparos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CD_W-1:0]  cool_q, cool_d;
  logic             disparo_ant_q, disparo_ant_d;

  logic tick_c;
  logic fire_c;

  // Next-state and datapath logic; pausa freezes everything except the edge detector.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    ativa_d       = ativa_q;
    disparos_d    = disparos_q;
    cnt_d         = cnt_q;
    cool_d        = cool_q;
    disparo_ant_d = disparo;

    tick_c = !pausa && (cnt_q == CNT_W'(TICK_DIV - 1));
    fire_c = disparo & ~disparo_ant_q;

    if (!pausa) begin
      cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);

      case (state_q)
        OCIOSA: begin
          if (fire_c) begin
            state_d = VOANDO;
            x_d     = nave_x + POS_W'(OFFSET_X);
            y_d     = nave_y;
            ativa_d = 1'b1;
            if (disparos_q != {DSP_W{1'b1}}) begin
              disparos_d = disparos_q + DSP_W'(1);
            end
          end
        end

        VOANDO: begin
          // A hit wins over a coincident tick; the top check uses the pre-move y.
          if (acerto || (tick_c && (y_q < POS_W'(Y_TOPO + VEL)))) begin
            state_d = RECARGA;
            x_d     = '0;
            y_d     = '0;
            ativa_d = 1'b0;
            cool_d  = '0;
          end else if (tick_c) begin
            y_d = y_q - POS_W'(VEL);
          end
        end

        RECARGA: begin
          if (tick_c) begin
            if (cool_q == CD_W'(RECARGA_TICKS - 1)) begin
              state_d = OCIOSA;
              cool_d  = '0;
            end else begin
              cool_d = cool_q + CD_W'(1);
            end
          end
        end

        default: begin
          state_d = OCIOSA;
          x_d     = '0;
          y_d     = '0;
          ativa_d = 1'b0;
        end
      endcase
    end
  end

  // State register with synchronous clear from reset or game restart.
  always_ff @(posedge CLOCK_50) begin
    if (reset || reiniciarJogo) begin
      state_q       <= OCIOSA;
      x_q           <= '0;
      y_q           <= '0;
      ativa_q       <= 1'b0;
      disparos_q    <= '0;
      cnt_q         <= '0;
      cool_q        <= '0;
      disparo_ant_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      ativa_q       <= ativa_d;
      disparos_q    <= disparos_d;
      cnt_q         <= cnt_d;
      cool_q        <= cool_d;
      disparo_ant_q <= disparo_ant_d;
    end
  end

  assign bola_nave_x = x_q;
  assign bola_nave_y = y_q;
  assign ativa       = ativa_q;
  assign disparos    = disparos_q;

endmodule

// File: tb/tb_tiro_nave.sv
// Scoreboard bench for tiro_nave with a short tick period (TICK_DIV=4).
// The driver pushes expected outputs into a queue; the monitor pops and
// compares them on the falling edge following each push.
module tb_tiro_nave;

  localparam int unsigned TICK_DIV      = 4;
  localparam int unsigned VEL           = 4;
  localparam int unsigned OFFSET_X      = 16;
  localparam int unsigned Y_TOPO        = 8;
  localparam int unsigned RECARGA_TICKS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reiniciarJogo = 1'b0;
  logic       pausa = 1'b0;
  logic       disparo = 1'b0;
  logic [9:0] nave_x = '0;
  logic [9:0] nave_y = '0;
  logic       acerto = 1'b0;
  logic [9:0] bola_nave_x;
  logic [9:0] bola_nave_y;
  logic       ativa;
  logic [7:0] disparos;

  tiro_nave #(
    .TICK_DIV(TICK_DIV), .VEL(VEL), .OFFSET_X(OFFSET_X),
    .Y_TOPO(Y_TOPO), .RECARGA_TICKS(RECARGA_TICKS)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .reiniciarJogo(reiniciarJogo), .pausa(pausa),
    .disparo(disparo), .nave_x(nave_x), .nave_y(nave_y), .acerto(acerto),
    .bola_nave_x(bola_nave_x), .bola_nave_y(bola_nave_y), .ativa(ativa),
    .disparos(disparos)
  );

  always #5 clk = ~clk;

  // Tick phase as the design is expected to see it: 0..3, held while paused.
  logic [1:0] tb_cnt = 2'd0;
  logic       tick_now;
  always @(posedge clk) begin
    if (reset || reiniciarJogo) tb_cnt <= 2'd0;
    else if (!pausa)            tb_cnt <= tb_cnt + 2'd1;
  end
  assign tick_now = (tb_cnt == 2'd3) && !pausa;

  typedef struct {
    logic       a;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] d;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_d  = 0;

  // Monitor: compare every pending expectation against the outputs.
  always @(negedge clk) begin : monitor
    exp_t  e;
    string t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (ativa !== e.a || bola_nave_x !== e.x || bola_nave_y !== e.y || disparos !== e.d) begin
        errors++;
        $display("FAIL %s: got ativa=%0b x=%0d y=%0d disparos=%0d, want ativa=%0b x=%0d y=%0d disparos=%0d",
                 t, ativa, bola_nave_x, bola_nave_y, disparos, e.a, e.x, e.y, e.d);
      end
    end
  end

  task automatic expect_out(input string tag, input logic a, input int x, input int y);
    exp_t e;
    e.a = a;
    e.x = 10'(x);
    e.y = 10'(y);
    e.d = 8'(exp_d);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycn(input int n);
    repeat (n) cyc();
  endtask

  // Advance until the next edge is a tick edge (bounded).
  task automatic to_pre_tick(input string tag);
    int n;
    n = 0;
    while (!tick_now && n < 16) begin
      cyc();
      n++;
    end
    if (!tick_now) begin
      checks++;
      errors++;
      $display("FAIL %s: no tick within 16 cycles", tag);
    end
  endtask

  // Advance through the next tick edge.
  task automatic to_tick(input string tag);
    to_pre_tick(tag);
    cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_d = 0;
    expect_out("reset", 1'b0, 0, 0);
  endtask

  task automatic launch(input string tag, input int x, input int y);
    nave_x  = 10'(x);
    nave_y  = 10'(y);
    disparo = 1'b1;
    cyc();
    disparo = 1'b0;
    exp_d   = (exp_d < 255) ? exp_d + 1 : 255;
    expect_out(tag, 1'b1, (x + OFFSET_X) % 1024, y);
  endtask

  task automatic retire_by_hit(input string tag);
    acerto = 1'b1;
    cyc();
    acerto = 1'b0;
    expect_out(tag, 1'b0, 0, 0);
  endtask

  task automatic finish_cooldown();
    to_tick("cool1");
    to_tick("cool2");
  endtask

  initial begin
    cycn(2);
    do_reset();

    // 1: launch and climb three ticks
    launch("launch", 100, 400);
    to_tick("t1");
    to_tick("t2");
    to_tick("t3");
    expect_out("climb3", 1'b1, 116, 388);
    retire_by_hit("hit_mid");
    finish_cooldown();

    // 2: top exit, cooldown length, press during cooldown dropped
    launch("launch_top", 100, 14);
    to_tick("top1");
    expect_out("top_first_tick", 1'b1, 116, 10);
    to_tick("top2");
    expect_out("top_exit", 1'b0, 0, 0);
    to_tick("rc1");
    disparo = 1'b1;
    cyc();
    disparo = 1'b0;
    expect_out("recarga_drop", 1'b0, 0, 0);
    cyc();
    to_tick("rc2");
    launch("relaunch_after_cool", 300, 200);

    // 3: hit coincident with tick, acerto ignored when idle
    to_tick("h1");
    expect_out("pre_hit", 1'b1, 316, 196);
    to_pre_tick("h2");
    acerto = 1'b1;
    cyc();
    acerto = 1'b0;
    expect_out("hit_on_tick", 1'b0, 0, 0);
    finish_cooldown();
    acerto = 1'b1;
    cycn(3);
    expect_out("acerto_ociosa", 1'b0, 0, 0);
    acerto = 1'b0;
    cyc();
    launch("launch_after_acerto", 100, 400);
    retire_by_hit("hit2");
    finish_cooldown();

    // 4: held button gives exactly one launch
    do_reset();
    nave_x  = 10'd50;
    nave_y  = 10'd14;
    disparo = 1'b1;
    cyc();
    exp_d = 1;
    expect_out("held_launch", 1'b1, 66, 14);
    to_tick("hd1");
    to_tick("hd2");
    expect_out("held_top_exit", 1'b0, 0, 0);
    finish_cooldown();
    cycn(3);
    expect_out("held_no_relaunch", 1'b0, 0, 0);
    disparo = 1'b0;
    cyc();
    launch("second_launch", 50, 300);
    retire_by_hit("hit3");
    finish_cooldown();

    // 5: pause mid-flight freezes motion and tick phase
    launch("launch_pause", 200, 400);
    to_tick("p1");
    expect_out("pre_pause", 1'b1, 216, 396);
    cyc();
    pausa = 1'b1;
    cycn(5);
    disparo = 1'b1;
    cyc();
    disparo = 1'b0;
    cycn(15);
    expect_out("pause_frozen", 1'b1, 216, 396);
    pausa = 1'b0;
    to_pre_tick("p2");
    expect_out("resume_pre_tick", 1'b1, 216, 396);
    cyc();
    expect_out("resume_tick", 1'b1, 216, 392);
    retire_by_hit("hit4");
    finish_cooldown();

    // Press edge while paused in OCIOSA is consumed, not deferred
    pausa   = 1'b1;
    disparo = 1'b1;
    cycn(3);
    expect_out("pause_no_launch", 1'b0, 0, 0);
    pausa = 1'b0;
    cycn(2);
    expect_out("held_after_pause", 1'b0, 0, 0);
    disparo = 1'b0;
    cyc();

    // 6: restart mid-flight, then saturation
    do_reset();
    repeat (4) begin
      launch("count_launch", 10, 200);
      retire_by_hit("count_hit");
      finish_cooldown();
    end
    launch("fifth_launch", 10, 200);
    reiniciarJogo = 1'b1;
    cyc();
    reiniciarJogo = 1'b0;
    exp_d = 0;
    expect_out("restart", 1'b0, 0, 0);
    cyc();

    for (int i = 0; i < 260; i++) begin
      launch("sat_launch", 1015, 100);
      retire_by_hit("sat_hit");
      finish_cooldown();
    end
    expect_out("saturated", 1'b0, 0, 0);

    cycn(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
